cdma_wg_rd_rsp_unpack: RTL



---
 rtl/cdma_wg_rd_rsp_unpack_if.sv | 25 ++
 rtl/cdma_wg_rd_rsp_unpack.sv | 87 ++++++++
 2 files changed

// File: rtl/cdma_wg_rd_rsp_unpack_if.sv
// Handshake bundle between the WG DMA read-response stage, the unpacker and the
// WG data-entry write logic: 514-bit response channel in, 256-bit beat channel out.
interface cdma_wg_rd_rsp_unpack_if #(
    parameter int HALF_W = 256
);
    logic                  dma_rd_rsp_vld;
    logic [2*HALF_W+1:0]   dma_rd_rsp_pd;
    logic                  dma_rd_rsp_rdy;
    logic                  unpk_vld;
    logic [HALF_W-1:0]     unpk_data;
    logic                  unpk_last;
    logic                  unpk_rdy;

    // Master: the response producer / beat consumer around the unpacker.
    modport master (
        output dma_rd_rsp_vld, dma_rd_rsp_pd, unpk_rdy,
        input  dma_rd_rsp_rdy, unpk_vld, unpk_data, unpk_last
    );

    // Slave: the unpacker itself.
    modport slave (
        input  dma_rd_rsp_vld, dma_rd_rsp_pd, unpk_rdy,
        output dma_rd_rsp_rdy, unpk_vld, unpk_data, unpk_last
    );
endinterface

// File: rtl/cdma_wg_rd_rsp_unpack.sv
// Splits each 514-bit WG read response into up to two 256-bit beats (low half first).
// Optional stall counter is built only when CDMA_WG_UNPACK_STALL_CNT_EN is defined.
module cdma_wg_rd_rsp_unpack #(
    parameter int HALF_W = 256,
    parameter int CNT_W  = 16
) (
    input  logic                     nvdla_core_clk,
    input  logic                     nvdla_core_rstn,
    cdma_wg_rd_rsp_unpack_if.slave   bus,
    output logic                     unpk_err_zero_mask,
    output logic [CNT_W-1:0]         unpk_rsp_cnt,
    output logic [CNT_W-1:0]         unpk_beat_cnt,
    output logic [31:0]              unpk_stall_cnt
);

    logic [2*HALF_W-1:0] buf_data_q;
    logic [1:0]          pend_q, pend_d;
    logic                err_q;
    logic [CNT_W-1:0]    rsp_cnt_q, beat_cnt_q;
    logic                out_fire;
    logic                accept;
    logic [1:0]          in_mask;

    assign in_mask = bus.dma_rd_rsp_pd[2*HALF_W+1:2*HALF_W];

    assign bus.unpk_vld  = |pend_q;
    assign bus.unpk_data = pend_q[0] ? buf_data_q[HALF_W-1:0] : buf_data_q[2*HALF_W-1:HALF_W];
    assign bus.unpk_last = (pend_q == 2'b01) || (pend_q == 2'b10);

    assign out_fire = bus.unpk_vld && bus.unpk_rdy;
    // Ready reopens in the same cycle the last beat leaves, so responses stream without a bubble.
    assign bus.dma_rd_rsp_rdy = (pend_q == 2'b00) || (out_fire && bus.unpk_last);
    assign accept = bus.dma_rd_rsp_vld && bus.dma_rd_rsp_rdy;

    always_comb begin
        // NOTE: default first so every path assigns pend_d and no latch is inferred.
        pend_d = pend_q;
        if (accept)
            pend_d = in_mask;
        else if (out_fire)
            pend_d = (pend_q == 2'b11) ? 2'b10 : 2'b00;
    end

    // NOTE: the wide data buffer is deliberately left without reset; pend_q qualifies it.
    always_ff @(posedge nvdla_core_clk) begin
        if (accept)
            buf_data_q <= bus.dma_rd_rsp_pd[2*HALF_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            pend_q     <= 2'b00;
            err_q      <= 1'b0;
            rsp_cnt_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            pend_q <= pend_d;
            err_q  <= accept && (in_mask == 2'b00);
            if (accept)
                rsp_cnt_q <= rsp_cnt_q + CNT_W'(1);
            if (out_fire)
                beat_cnt_q <= beat_cnt_q + CNT_W'(1);
        end
    end

    assign unpk_err_zero_mask = err_q;
    assign unpk_rsp_cnt       = rsp_cnt_q;
    assign unpk_beat_cnt      = beat_cnt_q;

`ifdef CDMA_WG_UNPACK_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Saturating count of cycles a beat waits on downstream backpressure.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn)
            stall_cnt_q <= 32'd0;
        else if (bus.unpk_vld && !bus.unpk_rdy && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign unpk_stall_cnt = stall_cnt_q;
`else
    assign unpk_stall_cnt = 32'd0;
`endif

endmodule
